// File: rtl/remote_cmd_sender.sv
// Host-side command initiator: sends opcode + 16-bit payload as three UART bytes,
// then waits for a one-byte response and classifies it as ack, nack or timeout.
module remote_cmd_sender #(
    parameter logic [7:0] ACK_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         TMR_W          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd_cmd,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic        busy,
    output logic        resp_rdy,
    output logic [7:0]  resp,
    output logic        ack,
    output logic        err
);

    // Handshake: trmt and clr_rx_rdy are single-cycle registered pulses; tx_done and
    // rx_rdy are levels owned by the UART, sampled on the rising edge of clk.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_TX   = 2'd2,
        WAIT_RESP = 2'd3
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_n;
    logic [23:0]       shift_q, shift_n;
    logic [1:0]        cnt_q, cnt_n;
    logic [TMR_W-1:0]  tmr_q, tmr_n;
    logic              skip_q, skip_n;
    logic              trmt_n, clr_n, resp_rdy_n, ack_n, err_n;
    logic [7:0]        resp_n;

    assign tx_data = shift_q[23:16];
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            tmr_q      <= '0;
            skip_q     <= 1'b0;
            trmt       <= 1'b0;
            clr_rx_rdy <= 1'b0;
            resp_rdy   <= 1'b0;
            resp       <= 8'h00;
            ack        <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            shift_q    <= shift_n;
            cnt_q      <= cnt_n;
            tmr_q      <= tmr_n;
            skip_q     <= skip_n;
            trmt       <= trmt_n;
            clr_rx_rdy <= clr_n;
            resp_rdy   <= resp_rdy_n;
            resp       <= resp_n;
            ack        <= ack_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        shift_n    = shift_q;
        cnt_n      = cnt_q;
        tmr_n      = tmr_q;
        skip_n     = skip_q;
        trmt_n     = 1'b0;
        clr_n      = 1'b0;
        resp_rdy_n = resp_rdy;
        resp_n     = resp;
        ack_n      = ack;
        err_n      = err;

        case (state)
            IDLE: begin
                if (snd_cmd) begin
                    shift_n    = {cmd, data};
                    cnt_n      = 2'd0;
                    resp_rdy_n = 1'b0;
                    ack_n      = 1'b0;
                    err_n      = 1'b0;
                    // Flush any byte that arrived before this command.
                    clr_n      = rx_rdy;
                    trmt_n     = 1'b1;
                    state_n    = SEND;
                end
            end
            SEND: begin
                skip_n  = 1'b1;
                state_n = WAIT_TX;
            end
            WAIT_TX: begin
                // tx_done still reflects the previous byte on the first cycle here.
                if (skip_q) begin
                    skip_n = 1'b0;
                end else if (tx_done) begin
                    if (cnt_q == 2'd2) begin
                        tmr_n   = '0;
                        state_n = WAIT_RESP;
                    end else begin
                        cnt_n   = cnt_q + 2'd1;
                        shift_n = {shift_q[15:0], 8'h00};
                        trmt_n  = 1'b1;
                        state_n = SEND;
                    end
                end
            end
            WAIT_RESP: begin
                tmr_n = tmr_q + 1'b1;
                if (rx_rdy) begin
                    resp_n     = rx_data;
                    clr_n      = 1'b1;
                    ack_n      = (rx_data == ACK_BYTE);
                    err_n      = (rx_data != ACK_BYTE);
                    resp_rdy_n = 1'b1;
                    state_n    = IDLE;
                end else if (tmr_q == TMR_LAST) begin
                    resp_n     = 8'h00;
                    ack_n      = 1'b0;
                    err_n      = 1'b1;
                    resp_rdy_n = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_remote_cmd_sender.sv
// Bench for remote_cmd_sender: behavioural UART tx/rx models plus scoreboards for the
// transmitted bytes and the classified response.
module tb_remote_cmd_sender;

    localparam int TOUT   = 100;
    localparam int TX_LEN = 4;

    typedef struct {
        logic [7:0] resp;
        logic       ack;
        logic       err;
        logic       clr;
        int         lat;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        snd_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        busy;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        ack;
    logic        err;

    logic [7:0]  exp_q[$];
    resp_t       exp_resp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int tx_bytes_done = 0;
    int last_txdone_cyc = 0;
    logic tx_busy = 1'b0;
    int rx_push = 0;
    int rx_served = 0;
    logic [7:0] rx_byte;

    remote_cmd_sender #(
        .ACK_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TOUT),
        .TMR_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .snd_cmd(snd_cmd),
        .cmd(cmd),
        .data(data),
        .trmt(trmt),
        .tx_data(tx_data),
        .tx_done(tx_done),
        .rx_rdy(rx_rdy),
        .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy),
        .busy(busy),
        .resp_rdy(resp_rdy),
        .resp(resp),
        .ack(ack),
        .err(err)
    );

    // Clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART tx model: tx_done stays stale for one cycle after trmt, then drops for TX_LEN cycles.
    initial begin
        tx_done = 1'b1;
        forever begin
            @(negedge clk);
            if (trmt) begin
                @(posedge clk); #1;
                tx_busy = 1'b1;
                @(posedge clk); #1;
                tx_done = 1'b0;
                repeat (TX_LEN) @(posedge clk);
                #1;
                tx_done = 1'b1;
                tx_busy = 1'b0;
                tx_bytes_done++;
                last_txdone_cyc = cyc;
            end
        end
    end

    // UART rx model: presents pushed bytes, drops rx_rdy the edge after clr_rx_rdy.
    initial begin
        logic clr_pending;
        clr_pending = 1'b0;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        forever begin
            @(posedge clk); #2;
            if (clr_pending) rx_rdy = 1'b0;
            clr_pending = clr_rx_rdy;
            if (rx_push != rx_served && !rx_rdy) begin
                rx_rdy  = 1'b1;
                rx_data = rx_byte;
                rx_served++;
            end
        end
    end

    // Monitor: transmitted bytes
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && trmt) begin
                chk("trmt while uart busy", {31'd0, tx_busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected trmt", 32'd1, 32'd0);
                end else begin
                    chk("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Monitor: responses
    initial begin
        logic  prev_rr;
        resp_t e;
        prev_rr = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_rdy && !prev_rr) begin
                if (exp_resp_q.size() == 0) begin
                    chk("unexpected resp_rdy", 32'd1, 32'd0);
                end else begin
                    e = exp_resp_q.pop_front();
                    chk("resp", {24'd0, resp}, {24'd0, e.resp});
                    chk("ack", {31'd0, ack}, {31'd0, e.ack});
                    chk("err", {31'd0, err}, {31'd0, e.err});
                    chk("busy at resp_rdy", {31'd0, busy}, 32'd0);
                    chk("clr_rx_rdy at resp_rdy", {31'd0, clr_rx_rdy}, {31'd0, e.clr});
                    if (e.lat >= 0) chk("resp latency", cyc - last_txdone_cyc, e.lat);
                end
            end
            prev_rr = resp_rdy;
        end
    end

    // Driver tasks
    task automatic push_cmd(input logic [7:0] c, input logic [15:0] d);
        exp_q.push_back(c);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endtask

    task automatic push_resp(input logic [7:0] r, input logic a, input logic e, input logic c, input int lat);
        resp_t x;
        x.resp = r; x.ack = a; x.err = e; x.clr = c; x.lat = lat;
        exp_resp_q.push_back(x);
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [15:0] d);
        snd_cmd = 1'b1;
        cmd     = c;
        data    = d;
        @(posedge clk); #1;
        snd_cmd = 1'b0;
    endtask

    task automatic give_rx(input logic [7:0] b);
        rx_byte = b;
        rx_push++;
    endtask

    task automatic wait_bytes(input int target);
        int n = 0;
        while (tx_bytes_done < target && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (tx_bytes_done < target) chk("wait tx bytes", tx_bytes_done, target);
    endtask

    task automatic wait_resp();
        int n = 0;
        while (!resp_rdy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!resp_rdy) chk("wait resp_rdy", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [7:0] c, input logic [15:0] d, input logic [7:0] r);
        int base;
        base = tx_bytes_done;
        push_cmd(c, d);
        push_resp(r, r == 8'hA5, r != 8'hA5, 1'b1, -1);
        send_cmd(c, d);
        wait_bytes(base + 3);
        repeat (5) @(posedge clk);
        #1;
        give_rx(r);
        wait_resp();
    endtask

    // Stimulus
    initial begin
        int base;
        int target;
        int n;
        rst = 1'b1; snd_cmd = 1'b0; cmd = 8'h00; data = 16'h0000; rx_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset trmt", {31'd0, trmt}, 32'd0);
        chk("reset clr_rx_rdy", {31'd0, clr_rx_rdy}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset resp_rdy", {31'd0, resp_rdy}, 32'd0);
        chk("reset ack", {31'd0, ack}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset resp", {24'd0, resp}, 32'd0);
        chk("reset tx_data", {24'd0, tx_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Ack, then nack
        run_cmd(8'h05, 16'h1234, 8'hA5);
        run_cmd(8'h05, 16'h1234, 8'hFF);

        // Timeout: no response byte
        base = tx_bytes_done;
        push_cmd(8'h42, 16'h00FF);
        push_resp(8'h00, 1'b0, 1'b1, 1'b0, TOUT + 1);
        send_cmd(8'h42, 16'h00FF);
        wait_bytes(base + 3);
        wait_resp();

        // Response arrives on the terminal-count cycle
        base = tx_bytes_done;
        push_cmd(8'h81, 16'hC3D4);
        push_resp(8'hA5, 1'b1, 1'b0, 1'b1, TOUT + 1);
        send_cmd(8'h81, 16'hC3D4);
        wait_bytes(base + 3);
        target = last_txdone_cyc + TOUT;
        do begin
            @(posedge clk); #1;
        end while (cyc < target);
        give_rx(8'hA5);
        wait_resp();

        // Stale rx byte at accept, second request during byte 2
        give_rx(8'h77);
        @(posedge clk); #1;
        base = tx_bytes_done;
        push_cmd(8'hA1, 16'h0203);
        push_resp(8'hA5, 1'b1, 1'b0, 1'b1, -1);
        send_cmd(8'hA1, 16'h0203);
        wait_bytes(base + 1);
        repeat (3) @(posedge clk);
        #1;
        send_cmd(8'hEE, 16'hFFFF);
        chk("stale rx flushed", {31'd0, rx_rdy}, 32'd0);
        wait_bytes(base + 3);
        repeat (4) @(posedge clk);
        #1;
        give_rx(8'hA5);
        wait_resp();

        // Asynchronous reset during byte 2
        base = tx_bytes_done;
        push_cmd(8'h11, 16'h2233);
        send_cmd(8'h11, 16'h2233);
        wait_bytes(base + 1);
        n = 0;
        while (!tx_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst trmt", {31'd0, trmt}, 32'd0);
        chk("midrst clr_rx_rdy", {31'd0, clr_rx_rdy}, 32'd0);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst resp_rdy", {31'd0, resp_rdy}, 32'd0);
        chk("midrst ack", {31'd0, ack}, 32'd0);
        chk("midrst err", {31'd0, err}, 32'd0);
        chk("midrst resp", {24'd0, resp}, 32'd0);
        chk("midrst tx_data", {24'd0, tx_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("aborted bytes left", exp_q.size(), 32'd1);
        exp_q.delete();
        n = 0;
        while (tx_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        run_cmd(8'h3C, 16'hBEEF, 8'hFF);

        repeat (20) @(posedge clk);
        #1;
        chk("tx queue drained", exp_q.size(), 32'd0);
        chk("resp queue drained", exp_resp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
